// File: rtl/ysyx_24080006_axi_rd_arbiter_if.sv
// Read-channel bundle between NUM_M upstream read masters, the arbiter and
// the shared downstream AXI read port. The arbiter takes the slave modport;
// the environment (masters + downstream port) takes the master modport.
interface ysyx_24080006_axi_rd_arbiter_if #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  // upstream AR, flattened per master (master i at [i*W +: W])
  logic [NUM_M-1:0]        m_arvalid;
  logic [NUM_M*ADDR_W-1:0] m_araddr;
  logic [NUM_M*ID_W-1:0]   m_arid;
  logic [NUM_M*8-1:0]      m_arlen;
  logic [NUM_M*3-1:0]      m_arsize;
  logic [NUM_M*2-1:0]      m_arburst;
  logic [NUM_M-1:0]        m_arready;
  // upstream R, payload shared and qualified by m_rvalid[i]
  logic [NUM_M-1:0]        m_rvalid;
  logic [DATA_W-1:0]       m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rlast;
  logic [ID_W-1:0]         m_rid;
  logic [NUM_M-1:0]        m_rready;
  // downstream AR
  logic                    s_arvalid;
  logic [ADDR_W-1:0]       s_araddr;
  logic [ID_W-1:0]         s_arid;
  logic [7:0]              s_arlen;
  logic [2:0]              s_arsize;
  logic [1:0]              s_arburst;
  logic                    s_arready;
  // downstream R
  logic                    s_rvalid;
  logic [DATA_W-1:0]       s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rlast;
  logic [ID_W-1:0]         s_rid;
  logic                    s_rready;

  modport slave (
    input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
           s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
           s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready
  );

  modport master (
    output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
           s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
           s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready
  );
endinterface

// File: rtl/ysyx_24080006_axi_rd_arbiter.sv
// N-master AXI4 read arbiter: one transaction in flight, bursts supported.
// IDLE picks a winner and pulses its arready while latching its AR fields,
// AR replays them downstream, R forwards beats until rlast.
// Optional macro YSYX_24080006_ARB_RR_EN: round-robin arbitration starting
// at a pointer that advances past each completed grant. Without it, fixed
// priority (master 0 highest) and no pointer register.
module ysyx_24080006_axi_rd_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  ysyx_24080006_axi_rd_arbiter_if.slave bus,
  output logic                         busy,
  output logic [IDX_W-1:0]             gnt_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;

  logic [1:0]        state;
  logic [IDX_W-1:0]  win;
  logic              found;
  logic              r_done;
  logic [ADDR_W-1:0] ar_addr;
  logic [ID_W-1:0]   ar_id;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;

  assign r_done = (state == R) & bus.s_rvalid & bus.s_rready & bus.s_rlast;

`ifdef YSYX_24080006_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] nxt_idx;
  int               rr_idx;

  assign nxt_idx = (int'(gnt_idx) == NUM_M - 1) ? '0 : gnt_idx + 1'b1;

  // round-robin search: first requester at ptr, ptr+1, ... modulo NUM_M
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 0; k < NUM_M; k++) begin
      rr_idx = int'(ptr) + k;
      if (rr_idx >= NUM_M) rr_idx = rr_idx - NUM_M;
      if (!found && bus.m_arvalid[rr_idx]) begin
        win   = IDX_W'(rr_idx);
        found = 1'b1;
      end
    end
  end

  // pointer moves just past the master whose burst has completed
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       ptr <= '0;
    else if (r_done) ptr <= nxt_idx;
  end
`else
  // fixed priority: lowest requesting index wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (!found && bus.m_arvalid[k]) begin
        win   = IDX_W'(k);
        found = 1'b1;
      end
    end
  end
`endif

  // transaction FSM; AR fields and winner are captured on the grant cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          state    <= AR;
          gnt_idx  <= win;
          ar_addr  <= bus.m_araddr[int'(win)*ADDR_W +: ADDR_W];
          ar_id    <= bus.m_arid[int'(win)*ID_W +: ID_W];
          ar_len   <= bus.m_arlen[int'(win)*8 +: 8];
          ar_size  <= bus.m_arsize[int'(win)*3 +: 3];
          ar_burst <= bus.m_arburst[int'(win)*2 +: 2];
        end
        AR:      if (bus.s_arready) state <= R;
        R:       if (r_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // per-master handshakes: only the winner/grantee ever sees a high bit;
  // arready is also masked by reset so nothing is accepted while held
  always_comb begin
    bus.m_arready = '0;
    bus.m_rvalid  = '0;
    if (state == IDLE && found && !reset) bus.m_arready[win] = 1'b1;
    if (state == R) bus.m_rvalid[gnt_idx] = bus.s_rvalid;
  end

  assign bus.s_arvalid = (state == AR);
  assign bus.s_araddr  = ar_addr;
  assign bus.s_arid    = ar_id;
  assign bus.s_arlen   = ar_len;
  assign bus.s_arsize  = ar_size;
  assign bus.s_arburst = ar_burst;

  // R payload passes straight through in R; zero otherwise so stray beats
  // outside a transaction never reach the masters
  assign bus.s_rready  = (state == R) & bus.m_rready[gnt_idx];
  assign bus.m_rdata   = (state == R) ? bus.s_rdata : '0;
  assign bus.m_rresp   = (state == R) ? bus.s_rresp : '0;
  assign bus.m_rlast   = (state == R) ? bus.s_rlast : 1'b0;
  assign bus.m_rid     = (state == R) ? bus.s_rid   : '0;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ysyx_24080006_axi_rd_arbiter.sv
// Directed bench for the read arbiter (NUM_M=2). Inputs change and outputs
// are sampled just after the falling edge; the DUT acts on the rising edge.
module tb_ysyx_24080006_axi_rd_arbiter;
  localparam int NUM_M = 2, ADDR_W = 32, DATA_W = 32, ID_W = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [0:0] gnt_idx;
  int         errors = 0;
  int         checks = 0;

  ysyx_24080006_axi_rd_arbiter_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  ysyx_24080006_axi_rd_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .gnt_idx(gnt_idx)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.m_arvalid = '0; bus.m_araddr = '0; bus.m_arid = '0; bus.m_arlen = '0;
    bus.m_arsize = '0; bus.m_arburst = '0; bus.m_rready = '0;
    bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = '0;
    bus.s_rresp = 2'b00; bus.s_rlast = 1'b0; bus.s_rid = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    bus.m_araddr[i*ADDR_W +: ADDR_W] = addr;
    bus.m_arid[i*ID_W +: ID_W]       = id;
    bus.m_arlen[i*8 +: 8]            = len;
    bus.m_arsize[i*3 +: 3]           = 3'd2;
    bus.m_arburst[i*2 +: 2]          = 2'b01;
    bus.m_arvalid[i]                 = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.m_arvalid = 2'b11; bus.m_rready = 2'b11; bus.s_arready = 1'b1;
    bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
    tick(); tick(); #1;
    checks++; if (bus.m_arready !== 2'b00) begin errors++; $display("FAIL reset_arready got=%b want=00", bus.m_arready); end
    checks++; if (bus.m_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b want=00", bus.m_rvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (bus.s_arvalid !== 1'b0) begin errors++; $display("FAIL reset_s_arvalid got=%b want=0", bus.s_arvalid); end
    checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL reset_s_rready got=%b want=0", bus.s_rready); end
    checks++; if (gnt_idx !== 1'b0) begin errors++; $display("FAIL reset_gnt_idx got=%0d want=0", gnt_idx); end
    checks++; if (bus.s_araddr !== 32'h0) begin errors++; $display("FAIL reset_s_araddr got=%h want=0", bus.s_araddr); end
    checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got=%h want=0", bus.m_rdata); end
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] beat_data [4];
    int          ar_pulses;
    beat_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    ar_pulses = 0;
    set_req(0, 32'h8000_0000, 4'h5, 8'd3); bus.m_rready = 2'b01; #1;
    checks++; if (bus.m_arready !== 2'b01) begin errors++; $display("FAIL single_arready got=%b want=01", bus.m_arready); end
    if (bus.m_arready[0]) ar_pulses++;
    for (int c = 0; c < 3; c++) begin
      tick(); bus.m_arvalid = '0; bus.s_arready = (c == 2); #1;
      if (bus.m_arready[0]) ar_pulses++;
      checks++; if (bus.s_arvalid !== 1'b1) begin errors++; $display("FAIL single_s_arvalid c=%0d got=%b want=1", c, bus.s_arvalid); end
      checks++; if (bus.s_araddr !== 32'h8000_0000) begin errors++; $display("FAIL single_s_araddr c=%0d got=%h want=80000000", c, bus.s_araddr); end
      checks++; if (bus.s_arlen !== 8'd3 || bus.s_arid !== 4'h5) begin errors++; $display("FAIL single_s_arlen_id got=%0d/%h want=3/5", bus.s_arlen, bus.s_arid); end
      checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL single_ar_s_rready got=%b want=0", bus.s_rready); end
    end
    for (int b = 0; b < 4; b++) begin
      tick(); bus.s_arready = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = beat_data[b];
      bus.s_rlast = (b == 3); bus.s_rid = 4'h5; #1;
      if (bus.m_arready[0]) ar_pulses++;
      checks++; if (bus.m_rvalid !== 2'b01) begin errors++; $display("FAIL single_m_rvalid b=%0d got=%b want=01", b, bus.m_rvalid); end
      checks++; if (bus.m_rdata !== beat_data[b]) begin errors++; $display("FAIL single_m_rdata b=%0d got=%h want=%h", b, bus.m_rdata, beat_data[b]); end
      checks++; if (bus.m_rlast !== (b == 3)) begin errors++; $display("FAIL single_m_rlast b=%0d got=%b want=%b", b, bus.m_rlast, (b == 3)); end
      checks++; if (bus.s_rready !== 1'b1) begin errors++; $display("FAIL single_s_rready b=%0d got=%b want=1", b, bus.s_rready); end
    end
    tick(); bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    checks++; if (ar_pulses !== 1) begin errors++; $display("FAIL single_ar_pulses got=%0d want=1", ar_pulses); end
    clear_inputs();
  endtask

  task automatic test_arb();
    int          exp_g [4];
    logic [31:0] rd [4];
`ifdef YSYX_24080006_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    rd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_reset();
    set_req(0, 32'h1000, 4'h1, 8'd0); set_req(1, 32'h2000, 4'h2, 8'd0);
    bus.s_arready = 1'b1; bus.m_rready = 2'b11; bus.s_rlast = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      checks++; if (bus.m_arready !== 2'(1 << exp_g[g])) begin errors++; $display("FAIL arb_arready g=%0d got=%b want=%b", g, bus.m_arready, 2'(1 << exp_g[g])); end
      tick(); #1;
      checks++; if (gnt_idx !== 1'(exp_g[g])) begin errors++; $display("FAIL arb_gnt_idx g=%0d got=%0d want=%0d", g, gnt_idx, exp_g[g]); end
      checks++; if (bus.s_araddr !== (exp_g[g] == 1 ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL arb_s_araddr g=%0d got=%h", g, bus.s_araddr); end
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = rd[g]; #1;
      checks++; if (bus.m_rvalid !== 2'(1 << exp_g[g])) begin errors++; $display("FAIL arb_m_rvalid g=%0d got=%b want=%b", g, bus.m_rvalid, 2'(1 << exp_g[g])); end
      checks++; if (bus.m_rdata !== rd[g]) begin errors++; $display("FAIL arb_m_rdata g=%0d got=%h want=%h", g, bus.m_rdata, rd[g]); end
      tick(); bus.s_rvalid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_isolation();
    set_req(1, 32'h3000, 4'h7, 8'd0); bus.m_rready = 2'b01; #1;
    checks++; if (bus.m_arready !== 2'b10) begin errors++; $display("FAIL iso_arready got=%b want=10", bus.m_arready); end
    tick(); bus.m_arvalid = '0; bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1; bus.s_rid = 4'h7; #1;
    checks++; if (bus.s_rready !== 1'b0 || bus.m_rvalid !== 2'b00) begin errors++; $display("FAIL iso_ar_spurious got=%b/%b want=0/00", bus.s_rready, bus.m_rvalid); end
    checks++; if (gnt_idx !== 1'b1) begin errors++; $display("FAIL iso_gnt_idx got=%0d want=1", gnt_idx); end
    tick(); bus.s_arready = 1'b1; bus.s_rvalid = 1'b0; #1;
    tick(); bus.s_arready = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 32'h77; #1;
    checks++; if (bus.m_rvalid !== 2'b10) begin errors++; $display("FAIL iso_m_rvalid got=%b want=10", bus.m_rvalid); end
    checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL iso_s_rready_other got=%b want=0", bus.s_rready); end
    tick(); bus.m_rready = 2'b11; #1;
    checks++; if (bus.s_rready !== 1'b1 || bus.m_rid !== 4'h7) begin errors++; $display("FAIL iso_accept got=%b/%h want=1/7", bus.s_rready, bus.m_rid); end
    tick(); #1;
    checks++; if (busy !== 1'b0 || bus.s_rready !== 1'b0 || bus.m_rvalid !== 2'b00) begin
      errors++; $display("FAIL iso_idle_spurious got busy=%b s_rready=%b m_rvalid=%b want 0/0/00", busy, bus.s_rready, bus.m_rvalid); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    set_req(0, 32'h4000, 4'h3, 8'd1); bus.m_rready = 2'b01; #1;
    checks++; if (bus.m_arready !== 2'b01) begin errors++; $display("FAIL bp_arready got=%b want=01", bus.m_arready); end
    tick(); bus.m_arvalid = '0; bus.s_arready = 1'b1; #1;
    tick(); bus.s_arready = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 32'hA1; bus.s_rresp = 2'b10; #1;
    if (bus.s_rready) accepted++;
    checks++; if (bus.m_rdata !== 32'hA1 || bus.m_rresp !== 2'b10) begin errors++; $display("FAIL bp_beat1 got=%h/%b want=a1/10", bus.m_rdata, bus.m_rresp); end
    tick(); bus.s_rdata = 32'hB2; bus.s_rresp = 2'b00; bus.s_rlast = 1'b1; bus.m_rready = 2'b00;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      #1;
      if (bus.s_rready) accepted++;
      checks++; if (bus.s_rready !== 1'b0) begin errors++; $display("FAIL bp_stall_s_rready c=%0d got=%b want=0", c, bus.s_rready); end
      checks++; if (bus.m_rvalid !== 2'b01 || bus.m_rdata !== 32'hB2 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_stall_hold c=%0d got rvalid=%b data=%h busy=%b want 01/b2/1", c, bus.m_rvalid, bus.m_rdata, busy); end
    end
    tick(); bus.m_rready = 2'b01; #1;
    if (bus.s_rready) accepted++;
    checks++; if (bus.m_rlast !== 1'b1 || bus.m_rdata !== 32'hB2) begin errors++; $display("FAIL bp_beat2 got=%b/%h want=1/b2", bus.m_rlast, bus.m_rdata); end
    tick(); bus.s_rvalid = 1'b0; bus.s_rlast = 1'b0; #1;
    checks++; if (busy !== 1'b0 || accepted !== 2) begin errors++; $display("FAIL bp_done got busy=%b beats=%0d want 0/2", busy, accepted); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'h5000, 4'h1, 8'd3); bus.m_rready = 2'b01; #1;
    tick(); bus.m_arvalid = '0; bus.s_arready = 1'b1; #1;
    tick(); bus.s_arready = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 32'h1; #1;
    checks++; if (bus.m_rvalid !== 2'b01) begin errors++; $display("FAIL rmid_beat1 got=%b want=01", bus.m_rvalid); end
    tick(); bus.s_rdata = 32'h2; reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || gnt_idx !== 1'b0) begin errors++; $display("FAIL rmid_busy_gnt got=%b/%0d want=0/0", busy, gnt_idx); end
    checks++; if (bus.m_rvalid !== 2'b00 || bus.s_rready !== 1'b0 || bus.s_arvalid !== 1'b0 || bus.m_arready !== 2'b00) begin
      errors++; $display("FAIL rmid_outputs got rvalid=%b rready=%b arvalid=%b arready=%b want all 0", bus.m_rvalid, bus.s_rready, bus.s_arvalid, bus.m_arready); end
    checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got=%h want=0", bus.m_rdata); end
    tick(); reset = 1'b0; clear_inputs();
    set_req(0, 32'h6000, 4'h2, 8'd0); set_req(1, 32'h7000, 4'h3, 8'd0); bus.s_arready = 1'b1; #1;
    checks++; if (bus.m_arready !== 2'b01) begin errors++; $display("FAIL rmid_regrant got=%b want=01", bus.m_arready); end
    tick(); bus.m_arvalid = '0; #1;
    checks++; if (gnt_idx !== 1'b0 || bus.s_araddr !== 32'h6000) begin errors++; $display("FAIL rmid_ar got=%0d/%h want=0/6000", gnt_idx, bus.s_araddr); end
    tick(); bus.s_rvalid = 1'b1; bus.s_rlast = 1'b1; bus.m_rready = 2'b11; #1;
    checks++; if (bus.m_rvalid !== 2'b01) begin errors++; $display("FAIL rmid_r got=%b want=01", bus.m_rvalid); end
    tick(); clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_arb();
    test_isolation();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
